ofs_axis_multi_ch_checker: RTL and testbench
============================================

Name: ofs_axis_multi_ch_checker

Overview:
- Passive, synthesizable AXI4-S protocol checker for NUM_CH independent streams.
- Sits beside the FIM datapath at any stream tap point, e.g. PCIe or HSSI bridges.
- Detects handshake, stability, stall-timeout and packet-length violations per channel.
- Reports them as sticky status, first-error capture and per-channel packet counts, readable through CSR glue.

Parameters:
- NUM_CH, 4: number of monitored streams (1..16).
- TDATA_WIDTH, 512: tdata width per channel; tkeep width = TDATA_WIDTH/8.
- TUSER_WIDTH, 10: tuser width per channel (>=1).
- TIMEOUT_CYC, 4096: consecutive stall cycles that flag a timeout; 0 disables the check.
- MAX_PKT_BEATS, 64: maximum beats per packet, checked only with the optional feature.
- CNT_W, 32: width of each per-channel packet counter.

Ports:
- clk  in  1  monitor clock, shared by all channels.
- rst_n  in  1  asynchronous, active-low reset.
- tvalid  in  NUM_CH  per-channel tvalid.
- tready  in  NUM_CH  per-channel tready, observed only.
- tdata  in  NUM_CH*TDATA_WIDTH  flattened; channel i at [i*TDATA_WIDTH +: TDATA_WIDTH].
- tkeep  in  NUM_CH*TDATA_WIDTH/8  flattened.
- tlast  in  NUM_CH  per-channel tlast.
- tuser  in  NUM_CH*TUSER_WIDTH  flattened.
- err_clr  in  1  single-cycle pulse that clears sticky errors and the first-error capture.
- err_sts  out  NUM_CH*4  sticky error bits per channel: [0] DROP, [1] UNSTABLE, [2] TIMEOUT, [3] LEN.
- err_any  out  1  registered OR of err_sts.
- first_err_vld  out  1  the first-error capture is valid.
- first_err_ch  out  max(1,$clog2(NUM_CH))  channel of the first error.
- first_err_code  out  4  err bits of that channel at capture.
- pkt_cnt  out  NUM_CH*CNT_W  packets accepted per channel (tvalid&tready&tlast); saturating.

Behaviour:
- Reset: all outputs, counters and state are 0; per-channel FSM = IDLE. Reset is asserted asynchronously; its release is synchronized to clk.
- Per-channel FSM, evaluated on each posedge:
  - IDLE: if tvalid&!tready, capture {tdata,tkeep,tlast,tuser}, set stall_cnt=1 and go to PEND. Otherwise stay.
  - PEND, !tvalid: set DROP and go to IDLE.
  - PEND, tvalid: if the payload differs from the capture, set UNSTABLE; keep the original capture and report once per stall. If tready, go to IDLE; else increment stall_cnt.
- Timeout: when stall_cnt reaches TIMEOUT_CYC, set TIMEOUT once per stall. stall_cnt saturates at TIMEOUT_CYC and resets on leaving PEND.
- Latency: an error bit is visible one cycle after the offending sampled edge. err_any lags err_sts by one cycle.
- Simultaneous set and err_clr on the same edge: the set wins, so the bit stays 1.
- first_err: loads only when first_err_vld=0 and any bit sets. If several channels set on the same edge, the lowest index wins. It holds until err_clr.
- pkt_cnt: increments on tvalid&tready&tlast and saturates at all-ones. It is not cleared by err_clr, only by reset.
- Reset mid-stall: FSM returns to IDLE with no error recorded. Ports are never driven back onto the stream.

Optional Feature:
- Macro: OFS_AXIS_CHK_LEN_EN.
- Defined: a per-channel beat counter counts accepted beats since the last tlast. LEN is set on acceptance of beat MAX_PKT_BEATS+1 without tlast, once per packet. The counter restarts after tlast.
- Undefined: bit [3] is tied 0 and the beat counters are removed.

Test Plan:
- ch0: tvalid=1, tready=0 for 3 cycles, then tvalid=0 -> err_sts[0]=1 one cycle later; first_err_ch=0, first_err_code=4'b0001.
- ch2: stalled; tdata changes 0xA5 -> 0x5A on stall cycle 2 -> err_sts[9]=1 once; no DROP; accepted normally afterwards.
- TIMEOUT_CYC=16, ch1 stalled 20 cycles -> err_sts[6] sets exactly after the 16th stall cycle; no re-assert; err_clr then clears it.
- ch1 DROP and ch3 UNSTABLE on the same edge -> first_err_ch=1; err_clr coincident with a new ch3 error -> ch3 bit remains 1.
- 5 packets of 3 beats on ch0 -> pkt_cnt[0]=5. With OFS_AXIS_CHK_LEN_EN and MAX_PKT_BEATS=4, a 5-beat packet sets err_sts[3] on beat 5. Without the macro, err_sts[3] stays 0.
- rst_n asserted mid-stall -> all outputs 0 asynchronously; after release, no spurious DROP.

Source files
------------

// File: rtl/ofs_axis_multi_ch_checker_if.sv
// Bundle of NUM_CH parallel AXI4-Stream channels, flattened per signal.
// The checker attaches through the all-input monitor modport.
interface ofs_axis_multi_ch_checker_if #(
   parameter int NUM_CH      = 4,
   parameter int TDATA_WIDTH = 512,
   parameter int TUSER_WIDTH = 10
);
   logic [NUM_CH-1:0]               tvalid;
   logic [NUM_CH-1:0]               tready;
   logic [NUM_CH*TDATA_WIDTH-1:0]   tdata;
   logic [NUM_CH*TDATA_WIDTH/8-1:0] tkeep;
   logic [NUM_CH-1:0]               tlast;
   logic [NUM_CH*TUSER_WIDTH-1:0]   tuser;

   modport master  (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave   (input tvalid, tdata, tkeep, tlast, tuser, output tready);
   modport monitor (input tvalid, tready, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/ofs_axis_multi_ch_checker.sv
// Passive per-channel AXI4-Stream protocol checker: DROP, UNSTABLE, TIMEOUT and LEN errors.
// Packet-length (LEN) checking is built only when OFS_AXIS_CHK_LEN_EN is defined.
module ofs_axis_multi_ch_checker #(
   parameter int  NUM_CH        = 4,
   parameter int  TDATA_WIDTH   = 512,
   parameter int  TUSER_WIDTH   = 10,
   parameter int  TIMEOUT_CYC   = 4096,
   parameter int  MAX_PKT_BEATS = 64,
   parameter int  CNT_W         = 32,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ofs_axis_multi_ch_checker_if.monitor axis_i,
   input  logic                        err_clr_i,
   output logic [NUM_CH*4-1:0]         err_sts_o,
   output logic                        err_any_o,
   output logic                        first_err_vld_o,
   output logic [CH_W-1:0]             first_err_ch_o,
   output logic [3:0]                  first_err_code_o,
   output logic [NUM_CH*CNT_W-1:0]     pkt_cnt_o
);
   localparam int KEEP_W  = TDATA_WIDTH / 8;
   localparam int PAY_W   = TDATA_WIDTH + KEEP_W + 1 + TUSER_WIDTH;
   localparam int STALL_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYC);

   typedef enum logic {ST_IDLE, ST_PEND} state_e;

   // Assertion is immediate; release is re-timed so every flop leaves reset on the same edge.
   logic [1:0] rst_sync_q;
   logic       arst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign arst_n = rst_sync_q[1];

   logic [NUM_CH*4-1:0]     set_all;
   logic [NUM_CH*4-1:0]     err_q_all;
   logic [NUM_CH*4-1:0]     err_d_all;
   logic [NUM_CH*CNT_W-1:0] pkt_all;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic               vld, rdy, lst;
      logic [PAY_W-1:0]   pay;
      state_e             state_q, state_d;
      logic [PAY_W-1:0]   cap_q, cap_d;
      logic [STALL_W-1:0] stall_q, stall_d;
      logic               unst_rep_q, unst_rep_d;
      logic [3:0]         set_v, err_q, err_d;
      logic [CNT_W-1:0]   pkt_q, pkt_d;
      logic               len_set;

      assign vld = axis_i.tvalid[gi];
      assign rdy = axis_i.tready[gi];
      assign lst = axis_i.tlast[gi];
      assign pay = {axis_i.tdata[gi*TDATA_WIDTH +: TDATA_WIDTH],
                    axis_i.tkeep[gi*KEEP_W +: KEEP_W],
                    lst,
                    axis_i.tuser[gi*TUSER_WIDTH +: TUSER_WIDTH]};

      always_comb begin
         state_d    = state_q;
         cap_d      = cap_q;
         stall_d    = stall_q;
         unst_rep_d = unst_rep_q;
         set_v      = 4'b0000;
         case (state_q)
            ST_IDLE: begin
               if (vld && !rdy) begin
                  cap_d   = pay;
                  stall_d = STALL_W'(1);
                  state_d = ST_PEND;
               end
            end
            ST_PEND: begin
               if (!vld) begin
                  set_v[0]   = 1'b1;
                  state_d    = ST_IDLE;
                  stall_d    = '0;
                  unst_rep_d = 1'b0;
               end else begin
                  // Compare against the original capture so a drifting payload is reported once.
                  if ((pay != cap_q) && !unst_rep_q) begin
                     set_v[1]   = 1'b1;
                     unst_rep_d = 1'b1;
                  end
                  if (rdy) begin
                     state_d    = ST_IDLE;
                     stall_d    = '0;
                     unst_rep_d = 1'b0;
                  end else if (stall_q != STALL_MAX) begin
                     stall_d = stall_q + STALL_W'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         // Firing only on the transition into saturation gives one report per stall.
         if ((TIMEOUT_CYC != 0) && (stall_d == STALL_MAX) && (stall_q != STALL_MAX))
            set_v[2] = 1'b1;
         set_v[3] = len_set;
      end

      assign err_d = (err_q & {4{~err_clr_i}}) | set_v;
      assign pkt_d = (vld && rdy && lst && (pkt_q != {CNT_W{1'b1}})) ? pkt_q + CNT_W'(1) : pkt_q;

      always_ff @(posedge clk or negedge arst_n) begin
         if (!arst_n) begin
            state_q    <= ST_IDLE;
            cap_q      <= '0;
            stall_q    <= '0;
            unst_rep_q <= 1'b0;
            err_q      <= 4'b0000;
            pkt_q      <= '0;
         end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            stall_q    <= stall_d;
            unst_rep_q <= unst_rep_d;
            err_q      <= err_d;
            pkt_q      <= pkt_d;
         end
      end

`ifdef OFS_AXIS_CHK_LEN_EN
      localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 2);
      logic [BEAT_W-1:0] beat_q, beat_d;
      logic              len_rep_q, len_rep_d;

      // beat_q counts accepted beats of the open packet; reaching MAX means this beat overruns.
      always_comb begin
         beat_d    = beat_q;
         len_rep_d = len_rep_q;
         len_set   = 1'b0;
         if (vld && rdy) begin
            if ((beat_q >= BEAT_W'(MAX_PKT_BEATS)) && !len_rep_q) begin
               len_set   = 1'b1;
               len_rep_d = 1'b1;
            end
            if (lst) begin
               beat_d    = '0;
               len_rep_d = 1'b0;
            end else if (beat_q < BEAT_W'(MAX_PKT_BEATS + 1)) begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge arst_n) begin
         if (!arst_n) begin
            beat_q    <= '0;
            len_rep_q <= 1'b0;
         end else begin
            beat_q    <= beat_d;
            len_rep_q <= len_rep_d;
         end
      end
`else
      assign len_set = 1'b0;
`endif

      assign set_all[gi*4 +: 4]       = set_v;
      assign err_q_all[gi*4 +: 4]     = err_q;
      assign err_d_all[gi*4 +: 4]     = err_d;
      assign pkt_all[gi*CNT_W +: CNT_W] = pkt_q;
   end

   logic            fe_vld_q, fe_vld_d;
   logic [CH_W-1:0] fe_ch_q, fe_ch_d;
   logic [3:0]      fe_code_q, fe_code_d;
   logic            err_any_q;

   // A clear on the same edge as a new error re-arms the capture for that error.
   always_comb begin
      fe_vld_d  = fe_vld_q;
      fe_ch_d   = fe_ch_q;
      fe_code_d = fe_code_q;
      if (err_clr_i) begin
         fe_vld_d  = 1'b0;
         fe_ch_d   = '0;
         fe_code_d = 4'b0000;
      end
      if ((!fe_vld_q || err_clr_i) && (|set_all)) begin
         fe_vld_d = 1'b1;
         for (int ci = NUM_CH - 1; ci >= 0; ci--) begin
            if (|set_all[ci*4 +: 4]) begin
               fe_ch_d   = CH_W'(ci);
               fe_code_d = err_d_all[ci*4 +: 4];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         fe_vld_q  <= 1'b0;
         fe_ch_q   <= '0;
         fe_code_q <= 4'b0000;
         err_any_q <= 1'b0;
      end else begin
         fe_vld_q  <= fe_vld_d;
         fe_ch_q   <= fe_ch_d;
         fe_code_q <= fe_code_d;
         err_any_q <= |err_q_all;
      end
   end

   assign err_sts_o        = err_q_all;
   assign err_any_o        = err_any_q;
   assign first_err_vld_o  = fe_vld_q;
   assign first_err_ch_o   = fe_ch_q;
   assign first_err_code_o = fe_code_q;
   assign pkt_cnt_o        = pkt_all;
endmodule

// File: tb/tb_ofs_axis_multi_ch_checker.sv
// Directed self-checking bench for ofs_axis_multi_ch_checker (4 channels, 16-cycle timeout).
// Expected LEN behaviour follows OFS_AXIS_CHK_LEN_EN as compiled.
module tb_ofs_axis_multi_ch_checker;
   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int UW  = 4;
   localparam int CW  = 8;

`ifdef OFS_AXIS_CHK_LEN_EN
   localparam logic [15:0] LEN_EXP = 16'h0008;
`else
   localparam logic [15:0] LEN_EXP = 16'h0000;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            err_clr = 1'b0;
   logic [15:0]     err_sts;
   logic            err_any;
   logic            fe_vld;
   logic [1:0]      fe_ch;
   logic [3:0]      fe_code;
   logic [NCH*CW-1:0] pkt_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   ofs_axis_multi_ch_checker_if #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) bus ();

   ofs_axis_multi_ch_checker #(
      .NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW),
      .TIMEOUT_CYC(16), .MAX_PKT_BEATS(4), .CNT_W(CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .axis_i           (bus),
      .err_clr_i        (err_clr),
      .err_sts_o        (err_sts),
      .err_any_o        (err_any),
      .first_err_vld_o  (fe_vld),
      .first_err_ch_o   (fe_ch),
      .first_err_code_o (fe_code),
      .pkt_cnt_o        (pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic v, input logic r, input logic l, input logic [31:0] d);
      bus.tvalid[ch]           = v;
      bus.tready[ch]           = r;
      bus.tlast[ch]            = l;
      bus.tdata[ch*DW +: DW]   = d;
   endtask

   task automatic idle_all();
      bus.tvalid = '0;
      bus.tready = '0;
      bus.tlast  = '0;
      bus.tdata  = '0;
      bus.tkeep  = '1;
      bus.tuser  = '0;
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL reset_err_sts got=%h exp=0000", err_sts); end
      tests_run++;
      if (err_any !== 1'b0) begin tests_failed++; $display("FAIL reset_err_any got=%b exp=0", err_any); end
      tests_run++;
      if (fe_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_first_vld got=%b exp=0", fe_vld); end
      tests_run++;
      if (pkt_cnt !== '0) begin tests_failed++; $display("FAIL reset_pkt_cnt got=%h exp=0", pkt_cnt); end
      $display("[TB] reset: err_sts=%h err_any=%b first_vld=%b pkt_cnt=%h", err_sts, err_any, fe_vld, pkt_cnt);
   endtask

   task automatic test_drop();
      drive(0, 1'b1, 1'b0, 1'b0, 32'h11);
      repeat (3) step();
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL drop_stall_clean got=%h exp=0000", err_sts); end
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      tests_run++;
      if (err_sts !== 16'h0001) begin tests_failed++; $display("FAIL drop_err_sts got=%h exp=0001", err_sts); end
      tests_run++;
      if (err_any !== 1'b0) begin tests_failed++; $display("FAIL drop_err_any_lag got=%b exp=0", err_any); end
      tests_run++;
      if ({fe_vld, fe_ch, fe_code} !== {1'b1, 2'd0, 4'b0001})
         begin tests_failed++; $display("FAIL drop_first_err got=%b/%0d/%b exp=1/0/0001", fe_vld, fe_ch, fe_code); end
      step();
      tests_run++;
      if (err_any !== 1'b1) begin tests_failed++; $display("FAIL drop_err_any got=%b exp=1", err_any); end
      clear_errs();
      tests_run++;
      if ({err_sts, fe_vld} !== {16'h0, 1'b0}) begin tests_failed++; $display("FAIL drop_clear got=%h/%b exp=0000/0", err_sts, fe_vld); end
      step();
      $display("[TB] drop ch0: err_sts cleared=%h err_any=%b", err_sts, err_any);
   endtask

   task automatic test_unstable();
      drive(2, 1'b1, 1'b0, 1'b0, 32'hA5);
      step();
      drive(2, 1'b1, 1'b0, 1'b0, 32'h5A);
      step();
      tests_run++;
      if (err_sts !== 16'h0200) begin tests_failed++; $display("FAIL unstable_err_sts got=%h exp=0200", err_sts); end
      tests_run++;
      if ({fe_vld, fe_ch, fe_code} !== {1'b1, 2'd2, 4'b0010})
         begin tests_failed++; $display("FAIL unstable_first_err got=%b/%0d/%b exp=1/2/0010", fe_vld, fe_ch, fe_code); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL unstable_once got=%h exp=0000", err_sts); end
      drive(2, 1'b1, 1'b1, 1'b0, 32'h5A);
      step();
      drive(2, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL unstable_no_drop got=%h exp=0000", err_sts); end
      $display("[TB] unstable ch2: err_sts after accept=%h", err_sts);
   endtask

   task automatic test_timeout();
      drive(1, 1'b1, 1'b0, 1'b0, 32'h77);
      repeat (15) step();
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL timeout_early got=%h exp=0000", err_sts); end
      step();
      tests_run++;
      if (err_sts !== 16'h0040) begin tests_failed++; $display("FAIL timeout_set got=%h exp=0040", err_sts); end
      tests_run++;
      if ({fe_vld, fe_ch, fe_code} !== {1'b1, 2'd1, 4'b0100})
         begin tests_failed++; $display("FAIL timeout_first_err got=%b/%0d/%b exp=1/1/0100", fe_vld, fe_ch, fe_code); end
      clear_errs();
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL timeout_clear got=%h exp=0000", err_sts); end
      repeat (3) step();
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL timeout_no_rearm got=%h exp=0000", err_sts); end
      drive(1, 1'b1, 1'b1, 1'b0, 32'h77);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      $display("[TB] timeout ch1: err_sts after 20 stall cycles and clear=%h", err_sts);
   endtask

   task automatic test_simultaneous();
      drive(1, 1'b1, 1'b0, 1'b0, 32'h01);
      drive(3, 1'b1, 1'b0, 1'b0, 32'h33);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(3, 1'b1, 1'b0, 1'b0, 32'h34);
      step();
      tests_run++;
      if (err_sts !== 16'h2010) begin tests_failed++; $display("FAIL simul_err_sts got=%h exp=2010", err_sts); end
      tests_run++;
      if ({fe_vld, fe_ch, fe_code} !== {1'b1, 2'd1, 4'b0001})
         begin tests_failed++; $display("FAIL simul_first_err got=%b/%0d/%b exp=1/1/0001", fe_vld, fe_ch, fe_code); end
      drive(3, 1'b0, 1'b0, 1'b0, 32'h0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      tests_run++;
      if (err_sts !== 16'h1000) begin tests_failed++; $display("FAIL simul_set_wins got=%h exp=1000", err_sts); end
      clear_errs();
      $display("[TB] simultaneous ch1/ch3: err_sts after final clear=%h", err_sts);
   endtask

   task automatic test_pkt_len();
      for (int p = 0; p < 5; p++) begin
         for (int b = 0; b < 3; b++) begin
            drive(0, 1'b1, 1'b1, (b == 2), 32'(p * 16 + b));
            step();
         end
      end
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      tests_run++;
      if (pkt_cnt[0 +: CW] !== 8'd5) begin tests_failed++; $display("FAIL pkt_cnt_ch0 got=%0d exp=5", pkt_cnt[0 +: CW]); end
      for (int b = 0; b < 4; b++) begin
         drive(0, 1'b1, 1'b1, (b == 3), 32'h100 + 32'(b));
         step();
      end
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL len_4beat_ok got=%h exp=0000", err_sts); end
      for (int b = 0; b < 4; b++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(b));
         step();
      end
      tests_run++;
      if (err_sts !== 16'h0) begin tests_failed++; $display("FAIL len_beat4_clean got=%h exp=0000", err_sts); end
      drive(0, 1'b1, 1'b1, 1'b1, 32'h204);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (err_sts !== LEN_EXP) begin tests_failed++; $display("FAIL len_beat5 got=%h exp=%h", err_sts, LEN_EXP); end
      tests_run++;
      if (pkt_cnt[0 +: CW] !== 8'd7) begin tests_failed++; $display("FAIL pkt_cnt_ch0_7 got=%0d exp=7", pkt_cnt[0 +: CW]); end
      step();
      clear_errs();
      $display("[TB] packets ch0: pkt_cnt=%0d", pkt_cnt[0 +: CW]);
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) begin
         drive(3, 1'b1, 1'b1, 1'b1, 32'(i));
         step();
      end
      drive(3, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      tests_run++;
      if (pkt_cnt[3*CW +: CW] !== 8'hFF) begin tests_failed++; $display("FAIL pkt_cnt_sat got=%h exp=ff", pkt_cnt[3*CW +: CW]); end
      clear_errs();
      tests_run++;
      if ({pkt_cnt[3*CW +: CW], pkt_cnt[0 +: CW]} !== {8'hFF, 8'd7})
         begin tests_failed++; $display("FAIL pkt_cnt_kept_by_clr got=%h/%h exp=ff/07", pkt_cnt[3*CW +: CW], pkt_cnt[0 +: CW]); end
      $display("[TB] saturate ch3: pkt_cnt=%h", pkt_cnt[3*CW +: CW]);
   endtask

   task automatic test_reset_mid_stall();
      drive(1, 1'b1, 1'b0, 1'b0, 32'h9);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(2, 1'b1, 1'b0, 1'b0, 32'hC3);
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({err_sts, err_any, fe_vld, pkt_cnt} !== '0)
         begin tests_failed++; $display("FAIL async_reset got=%h/%b/%b/%h exp=0", err_sts, err_any, fe_vld, pkt_cnt); end
      idle_all();
      repeat (2) step();
      rst_n = 1'b1;
      repeat (5) step();
      tests_run++;
      if ({err_sts, fe_vld, pkt_cnt} !== '0)
         begin tests_failed++; $display("FAIL no_spurious_drop got=%h/%b/%h exp=0", err_sts, fe_vld, pkt_cnt); end
      $display("[TB] reset mid-stall: err_sts=%h after release", err_sts);
   endtask

   initial begin
      idle_all();
      repeat (3) step();
      test_reset();
      rst_n = 1'b1;
      repeat (4) step();
      test_reset();
      test_drop();
      test_unstable();
      test_timeout();
      test_simultaneous();
      test_pkt_len();
      test_saturate();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
